// File: rtl/sumador_multipalabra_pkg.sv
// Shared definitions for the multi-word adder/subtractor.
//   ancho_idx  : width of the word index (clog2 with a floor of 1 bit)
//   MODO_SUMA  : operation mode encoding for A+B
//   MODO_RESTA : operation mode encoding for A-B
package sumador_multipalabra_pkg;

    localparam logic MODO_SUMA  = 1'b0;
    localparam logic MODO_RESTA = 1'b1;

    // Index width for a counter running 0..p-1; a single-word operand still
    // needs a one-bit register so the port/signal widths stay legal.
    function automatic int ancho_idx(input int p);
        int w;
        w = $clog2(p);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sumador_multipalabra_sumador.sv
// Combinational N-bit adder used for one word of the multi-word datapath.
//   A, B : operand words (B already conditioned by the caller for subtraction)
//   Cin  : carry in
//   S    : sum word
//   Cout : carry out of the MSB
//   V    : two's-complement overflow of this word treated as the top word
module sumador #(
    parameter int N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic         V
);

    logic [N:0] total_s;

    assign total_s = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, Cin};
    assign S       = total_s[N-1:0];
    assign Cout    = total_s[N];
    // Overflow: both operands share a sign and the result sign differs.
    assign V       = (A[N-1] == B[N-1]) && (S[N-1] != A[N-1]);

endmodule

// File: rtl/sumador_multipalabra.sv
// Multi-precision adder/subtractor over PALABRAS words of N bits, LS word first.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input word handshake (A, B, resta, cin)
//   resta, cin          : mode and initial carry, taken from word 0 only
//   out_valid/out_ready : output word handshake (S, out_last, Cout, V)
//   out_last            : S is the most-significant word of the result
//   Cout, V             : final carry / signed overflow, non-zero only with out_last
module sumador_multipalabra
    import sumador_multipalabra_pkg::*;
#(
    parameter int N        = 8,
    parameter int PALABRAS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         resta,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         out_last,
    output logic         Cout,
    output logic         V
);

    localparam int IW = ancho_idx(PALABRAS);

    logic [IW-1:0] idx_r;
    logic          c_r;
    logic          m_r;
    logic [N-1:0]  s_r;
    logic          out_valid_r;
    logic          out_last_r;
    logic          cout_r;
    logic          v_r;

    logic          primera_s;
    logic          ultima_s;
    logic [IW-1:0] idx_sig_s;
    logic          me_s;
    logic          cin_s;
    logic [N-1:0]  b_op_s;
    logic [N-1:0]  suma_s;
    logic          cout_sum_s;
    logic          v_sum_s;
    logic          in_xfer_s;

    // The output register frees up when empty or when its word leaves this cycle.
    assign in_ready  = !out_valid_r || out_ready;
    assign in_xfer_s = in_valid && in_ready;

    assign primera_s = (idx_r == {IW{1'b0}});
    assign ultima_s  = (idx_r == IW'(PALABRAS - 1));
    assign idx_sig_s = ultima_s ? {IW{1'b0}} : (idx_r + IW'(1));

    // Word 0 takes mode and carry from the ports so nothing from a previous
    // operation leaks in; later words use the registered mode and carry chain.
    always_comb begin
        me_s  = m_r;
        cin_s = c_r;
        if (primera_s) begin
            me_s  = resta;
            cin_s = (resta == MODO_RESTA) ? 1'b1 : cin;
        end else begin
            me_s  = m_r;
            cin_s = c_r;
        end
        b_op_s = (me_s == MODO_RESTA) ? ~B : B;
    end

    sumador #(
        .N (N)
    ) u_sumador (
        .A    (A),
        .B    (b_op_s),
        .Cin  (cin_s),
        .S    (suma_s),
        .Cout (cout_sum_s),
        .V    (v_sum_s)
    );

    // Word index, carry/mode chain and registered output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r       <= {IW{1'b0}};
            c_r         <= 1'b0;
            m_r         <= MODO_SUMA;
            s_r         <= {N{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            cout_r      <= 1'b0;
            v_r         <= 1'b0;
        end else if (in_xfer_s) begin
            s_r         <= suma_s;
            c_r         <= cout_sum_s;
            out_valid_r <= 1'b1;
            out_last_r  <= ultima_s;
            cout_r      <= ultima_s ? cout_sum_s : 1'b0;
            v_r         <= ultima_s ? v_sum_s : 1'b0;
            idx_r       <= idx_sig_s;
            if (primera_s) begin
                m_r <= resta;
            end else begin
                m_r <= m_r;
            end
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign S         = s_r;
    assign out_last  = out_last_r;
    assign Cout      = cout_r;
    assign V         = v_r;

endmodule

// File: tb/tb_sumador_multipalabra.sv
module tb_sumador_multipalabra;

    typedef struct packed {
        logic [7:0] s;
        logic       last;
        logic       c;
        logic       v;
    } esp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic       resta;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] S;
    logic       out_last;
    logic       Cout;
    logic       V;

    esp_t cola[$];
    int   checks = 0;
    int   errors = 0;
    int   bp_cnt = 0;

    sumador_multipalabra #(.N(8), .PALABRAS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .resta     (resta),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .out_last  (out_last),
        .Cout      (Cout),
        .V         (V)
    );

    always #5 clk = ~clk;

    // One clock: drive at the falling edge, check the output word that will
    // be consumed at the next rising edge, report whether the input is taken.
    task automatic ciclo(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic r, input logic ci, output logic acc);
        esp_t e;
        @(negedge clk);
        in_valid = v;
        A        = a;
        B        = b;
        resta    = r;
        cin      = ci;
        if (bp_cnt > 0) begin
            out_ready = 1'b0;
            bp_cnt--;
        end else begin
            out_ready = 1'b1;
        end
        #1;
        if (!out_ready && out_valid) begin
            checks++;
            if (cola.size() == 0) begin
                errors++;
                $display("FAIL estancado_sin_esperado S=%h", S);
            end else if (S !== cola[0].s || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL estancado S=%h in_ready=%b esperado S=%h in_ready=0",
                         S, in_ready, cola[0].s);
            end
        end
        if (out_valid && out_ready) begin
            checks++;
            if (cola.size() == 0) begin
                errors++;
                $display("FAIL palabra_extra S=%h last=%b", S, out_last);
            end else begin
                e = cola.pop_front();
                if ({S, out_last, Cout, V} !== e) begin
                    errors++;
                    $display("FAIL palabra obtenido S=%h last=%b Cout=%b V=%b esperado S=%h last=%b Cout=%b V=%b",
                             S, out_last, Cout, V, e.s, e.last, e.c, e.v);
                end
            end
        end
        acc = v && in_ready;
    endtask

    // Sends npal words of one operation; later words carry a flipped resta
    // and the same cin to show those are ignored after word 0.
    task automatic enviar_op(input logic [31:0] a, input logic [31:0] b, input logic r,
                             input logic ci, input logic [31:0] er, input logic ec,
                             input logic ev, input int npal, input int bp_k);
        logic acc;
        int   t;
        esp_t e;
        for (int k = 0; k < npal; k++) begin
            acc = 1'b0;
            t   = 0;
            while (!acc && t < 50) begin
                ciclo(1'b1, a[8*k +: 8], b[8*k +: 8], (k == 0) ? r : ~r, ci, acc);
                t++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL timeout_entrada palabra=%0d obtenido in_ready=%b esperado 1", k, in_ready);
                return;
            end
            e.s    = er[8*k +: 8];
            e.last = (k == 3);
            e.c    = (k == 3) ? ec : 1'b0;
            e.v    = (k == 3) ? ev : 1'b0;
            cola.push_back(e);
            if (k == bp_k) begin
                bp_cnt = 3;
            end
        end
    endtask

    task automatic vaciar();
        logic acc;
        int   t;
        t = 0;
        while (cola.size() != 0 && t < 50) begin
            ciclo(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, acc);
            t++;
        end
        checks++;
        if (cola.size() != 0) begin
            errors++;
            $display("FAIL timeout_salida pendientes=%0d esperado 0", cola.size());
            cola.delete();
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = 8'h00;
        B         = 8'h00;
        resta     = 1'b0;
        cin       = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, S, out_last, Cout, V, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset obtenido ov=%b S=%h last=%b C=%b V=%b ir=%b esperado 0,00,0,0,0,1",
                     out_valid, S, out_last, Cout, V, in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_suma();
        enviar_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 4, -1);
        vaciar();
    endtask

    task automatic test_back_to_back();
        enviar_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 4, -1);
        enviar_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 4, -1);
        vaciar();
    endtask

    task automatic test_resta();
        enviar_op(32'h00000000, 32'h00000001, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 4, -1);
        enviar_op(32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 4, -1);
        vaciar();
    endtask

    task automatic test_backpressure();
        enviar_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 4, 1);
        vaciar();
    endtask

    task automatic test_reset_medio();
        enviar_op(32'h11223344, 32'h01010101, 1'b0, 1'b0, 32'h12233445, 1'b0, 1'b0, 3, -1);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checks++;
        if ({out_valid, S, out_last, Cout, V, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_medio obtenido ov=%b S=%h last=%b C=%b V=%b ir=%b esperado 0,00,0,0,0,1",
                     out_valid, S, out_last, Cout, V, in_ready);
        end
        cola.delete();
        @(negedge clk);
        rst_n = 1'b1;
        enviar_op(32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0, 4, -1);
        vaciar();
    endtask

    task automatic test_aleatorio();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] bb;
        logic [32:0] tot;
        logic        r;
        logic        ci;
        logic        ev;
        for (int i = 0; i < 10; i++) begin
            a   = $urandom;
            b   = $urandom;
            r   = 1'($urandom_range(1, 0));
            ci  = 1'($urandom_range(1, 0));
            bb  = r ? ~b : b;
            tot = {1'b0, a} + {1'b0, bb} + {32'h00000000, (r ? 1'b1 : ci)};
            ev  = (a[31] == bb[31]) && (tot[31] != a[31]);
            enviar_op(a, b, r, ci, tot[31:0], tot[32], ev, 4, -1);
        end
        vaciar();
    endtask

    initial begin
        test_reset();
        test_suma();
        test_back_to_back();
        test_resta();
        test_backpressure();
        test_reset_medio();
        test_aleatorio();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
